wb_master_mux: RTL and testbench
================================

Name: wb_master_mux

Overview:
- Parametrised Wishbone classic master that bridges the CPU data-memory port to N peripheral slaves (UART, SPI, VGA, and later additions).
- Successor to the fixed three-slave, write-only bridge. Adds:
  - read transactions
  - a generic slave count
  - latched request/address/data
  - error-ack and timeout termination
  - an explicit ready/err handshake back to the CPU load/store unit.

Parameters:
- N_SLAVES, 4, number of slave channels; must be 1..2**SEL_W.
- ADDR_W, 16, width of wb_adr_o (low address bits passed to slave).
- SEL_LSB, 16, LSB of the slave-select field in mem_addr_i.
- SEL_W, 2, width of the slave-select field.
- TIMEOUT, 255, BUS-state cycles before forced error termination; 0 disables the timeout.

Ports:
- clk_i, in, 1, clock.
- rst_n_i, in, 1, reset; asynchronous, active-low.
- mem_req_i, in, 1, CPU access request (level).
- mem_we_i, in, 4, byte write enables; nonzero = write, zero = read.
- mem_addr_i, in, 32, byte address.
- mem_data_i, in, 32, write data.
- mem_data_o, out, 32, registered read data.
- mem_ready_o, out, 1, one-cycle completion pulse.
- mem_err_o, out, 1, valid with mem_ready_o; transaction failed.
- s_ack_i, in, N_SLAVES, per-slave ack.
- s_err_i, in, N_SLAVES, per-slave error ack.
- s_data_i, in, 32*N_SLAVES, per-slave read data; slave k occupies bits [32k+31:32k].
- s_cyc_o, out, N_SLAVES, per-slave cycle (one-hot or zero).
- wb_stb_o, out, 1, shared strobe.
- wb_we_o, out, 1, shared write enable.
- wb_sel_o, out, 4, shared byte select.
- wb_adr_o, out, ADDR_W, shared address.
- wb_dat_o, out, 32, shared write data.

Behaviour:
- Reset (async, while rst_n_i=0): state=IDLE; all s_cyc_o, wb_stb_o, wb_we_o, mem_ready_o, mem_err_o = 0; wb_sel_o=0, wb_adr_o=0, wb_dat_o=0, mem_data_o=0, timeout counter=0. Reset mid-transaction drops cyc/stb immediately; no completion is reported.
- States: IDLE, BUS, DONE.
- IDLE, mem_req_i=0: stay in IDLE.
- IDLE, mem_req_i=1: latch the following, then leave IDLE.
  - idx = mem_addr_i[SEL_LSB+SEL_W-1:SEL_LSB]
  - wb_adr_o = mem_addr_i[ADDR_W-1:0]
  - wb_dat_o = mem_data_i
  - wb_we_o = |mem_we_i
  - wb_sel_o = mem_we_i for writes, 4'hF for reads
  - if idx >= N_SLAVES: go to DONE with err=1; no bus cycle issued.
  - otherwise: go to BUS and clear the counter.
- BUS outputs: s_cyc_o[idx]=1, wb_stb_o=1; all other cyc bits 0. Latched outputs are stable for the whole cycle.
- BUS termination, evaluated each cycle:
  - s_err_i[idx]=1 → DONE, err=1. Error wins over a simultaneous ack.
  - else s_ack_i[idx]=1 → DONE, err=0. On a read, mem_data_o <= s_data_i slice idx. On a write, mem_data_o is unchanged.
  - else if TIMEOUT!=0 and counter==TIMEOUT-1 → DONE, err=1. An ack arriving in the same cycle as timeout expiry wins.
  - else counter++ (width $clog2(TIMEOUT+1), saturating).
- Unselected slaves' ack/err/data are ignored at all times.
- DONE: mem_ready_o=1, mem_err_o=err for exactly one cycle; cyc/stb=0; next state IDLE.
  - On error, mem_data_o <= 0.
  - mem_req_i is ignored in DONE. If it is still high in the following IDLE cycle, a new transaction starts; the CPU drops mem_req_i on mem_ready_o to avoid a repeat.
- Latency: request sampled in cycle 0; stb high from cycle 1; ack in cycle 1 → mem_ready_o in cycle 2. Minimum 3 cycles per transaction; no pipelining, one outstanding transaction.
- mem_we_i/mem_addr_i/mem_data_i changes after cycle 0 have no effect on the transaction in flight.

Decomposition:
- Shared package wb_pkg holds:
  - typedef enum logic [1:0] {IDLE, BUS, DONE} wb_state_t
  - localparam WB_DW=32, WB_SELW=4
  - slave index constants UART_IDX=0, SPI_IDX=1, VGA_IDX=2
- One natural sub-module: wb_timeout_ctr, holding the saturating counter with clear/enable inputs, parameter TIMEOUT, and an expire output. The FSM and mux stay in the top.

Test Plan:
- Write 0xDEADBEEF, we=4'b0011, addr 0x0001_0024; slave 1 acks in its 2nd BUS cycle.
  - → s_cyc_o=4'b0010, wb_adr_o=0x0024, wb_sel_o=4'b0011, wb_we_o=1.
  - → mem_ready_o pulses 1 cycle in cycle 3, mem_err_o=0.
- Read, addr 0x0000_0008; slave 0 returns 0x12345678 with ack in cycle 1.
  - → wb_sel_o=4'hF, wb_we_o=0, mem_ready_o in cycle 2, mem_data_o=0x12345678 held afterwards.
- Read to idx 3 with N_SLAVES=3.
  - → no cyc/stb ever asserted; cycle 1 mem_ready_o=1, mem_err_o=1, mem_data_o=0.
- TIMEOUT=4, slave never acks.
  - → stb high exactly 4 cycles, then mem_ready_o=1 and mem_err_o=1.
  - Separately: ack together with s_err_i → err=1. Ack on the last timeout cycle → err=0.
- Assert rst_n_i low during BUS, asynchronously mid-cycle.
  - → s_cyc_o/wb_stb_o drop without a clock edge; no mem_ready_o; after release a new request completes normally.
- Hold mem_req_i high through DONE.
  - → second transaction begins at IDLE+1 (stb low for exactly 2 cycles between transactions); mem_we_i changes during BUS are ignored.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone bridge definitions: FSM state encoding, bus widths and
// the fixed slave slots of the peripheral map.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } wb_state_t;

    localparam int WB_DW   = 32;
    localparam int WB_SELW = 4;

    localparam int UART_IDX = 0;
    localparam int SPI_IDX  = 1;
    localparam int VGA_IDX  = 2;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Saturating bus-cycle counter; expire_o flags the last permitted BUS cycle.
// A TIMEOUT of zero disables expiry entirely.
module wb_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int            CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] MAX  = '1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt <= '0;
        end else if (clr_i) begin
            cnt <= '0;
        end else if (en_i && cnt != MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire_o = (TIMEOUT != 0) && (cnt == LAST);

endmodule

// File: rtl/wb_master_mux.sv
// Wishbone classic master bridging the CPU data port to N_SLAVES peripherals,
// one outstanding transaction, with error-ack and timeout termination.
module wb_master_mux
    import wb_pkg::*;
#(
    parameter int N_SLAVES = 4,
    parameter int ADDR_W   = 16,
    parameter int SEL_LSB  = 16,
    parameter int SEL_W    = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      mem_req_i,
    input  logic [WB_SELW-1:0]        mem_we_i,
    input  logic [31:0]               mem_addr_i,
    input  logic [WB_DW-1:0]          mem_data_i,
    output logic [WB_DW-1:0]          mem_data_o,
    output logic                      mem_ready_o,
    output logic                      mem_err_o,
    input  logic [N_SLAVES-1:0]       s_ack_i,
    input  logic [N_SLAVES-1:0]       s_err_i,
    input  logic [WB_DW*N_SLAVES-1:0] s_data_i,
    output logic [N_SLAVES-1:0]       s_cyc_o,
    output logic                      wb_stb_o,
    output logic                      wb_we_o,
    output logic [WB_SELW-1:0]        wb_sel_o,
    output logic [ADDR_W-1:0]         wb_adr_o,
    output logic [WB_DW-1:0]          wb_dat_o
);

    wb_state_t        state_q, state_d;
    logic [SEL_W-1:0] idx_q;
    logic [SEL_W-1:0] req_idx;
    logic             in_range;
    logic             err_q;
    logic             sel_ack;
    logic             sel_err;
    logic [WB_DW-1:0] sel_data;
    logic             expire;
    logic             unused_addr;

    assign req_idx     = mem_addr_i[SEL_LSB +: SEL_W];
    assign in_range    = int'(req_idx) < N_SLAVES;
    assign unused_addr = ^mem_addr_i;

    // Only the latched slave's response lines are looked at.
    always_comb begin
        sel_ack  = 1'b0;
        sel_err  = 1'b0;
        sel_data = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (idx_q == SEL_W'(k)) begin
                sel_ack  = s_ack_i[k];
                sel_err  = s_err_i[k];
                sel_data = s_data_i[k*WB_DW +: WB_DW];
            end
        end
    end

    wb_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .clr_i    (state_q != BUS),
        .en_i     (state_q == BUS),
        .expire_o (expire)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (mem_req_i) state_d = in_range ? BUS : DONE;
            BUS:     if (sel_err || sel_ack || expire) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_cyc_o     = '0;
        wb_stb_o    = 1'b0;
        mem_ready_o = 1'b0;
        mem_err_o   = 1'b0;
        unique case (state_q)
            BUS: begin
                wb_stb_o = 1'b1;
                for (int k = 0; k < N_SLAVES; k++) begin
                    s_cyc_o[k] = (idx_q == SEL_W'(k));
                end
            end
            DONE: begin
                mem_ready_o = 1'b1;
                mem_err_o   = err_q;
            end
            default: ;
        endcase
    end

    // Request fields are captured once in IDLE and held for the whole transaction.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            idx_q      <= '0;
            err_q      <= 1'b0;
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            wb_we_o    <= 1'b0;
            wb_sel_o   <= '0;
            mem_data_o <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (mem_req_i) begin
                        idx_q    <= req_idx;
                        wb_adr_o <= mem_addr_i[ADDR_W-1:0];
                        wb_dat_o <= mem_data_i;
                        wb_we_o  <= |mem_we_i;
                        wb_sel_o <= (|mem_we_i) ? mem_we_i : '1;
                        err_q    <= !in_range;
                        if (!in_range) mem_data_o <= '0;
                    end
                end
                BUS: begin
                    if (sel_err) begin
                        err_q      <= 1'b1;
                        mem_data_o <= '0;
                    end else if (sel_ack) begin
                        err_q <= 1'b0;
                        if (!wb_we_o) mem_data_o <= sel_data;
                    end else if (expire) begin
                        err_q      <= 1'b1;
                        mem_data_o <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_master_mux.sv
// Scoreboard bench for wb_master_mux with three slaves and a short timeout.
module tb_wb_master_mux;
    import wb_pkg::*;

    localparam int NS = 3;
    localparam int TO = 4;

    logic            clk_i;
    logic            rst_n_i;
    logic            mem_req_i;
    logic [3:0]      mem_we_i;
    logic [31:0]     mem_addr_i;
    logic [31:0]     mem_data_i;
    logic [31:0]     mem_data_o;
    logic            mem_ready_o;
    logic            mem_err_o;
    logic [NS-1:0]   s_ack_i;
    logic [NS-1:0]   s_err_i;
    logic [32*NS-1:0] s_data_i;
    logic [NS-1:0]   s_cyc_o;
    logic            wb_stb_o;
    logic            wb_we_o;
    logic [3:0]      wb_sel_o;
    logic [15:0]     wb_adr_o;
    logic [31:0]     wb_dat_o;

    wb_master_mux #(
        .N_SLAVES (NS),
        .ADDR_W   (16),
        .SEL_LSB  (16),
        .SEL_W    (2),
        .TIMEOUT  (TO)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .mem_req_i   (mem_req_i),
        .mem_we_i    (mem_we_i),
        .mem_addr_i  (mem_addr_i),
        .mem_data_i  (mem_data_i),
        .mem_data_o  (mem_data_o),
        .mem_ready_o (mem_ready_o),
        .mem_err_o   (mem_err_o),
        .s_ack_i     (s_ack_i),
        .s_err_i     (s_err_i),
        .s_data_i    (s_data_i),
        .s_cyc_o     (s_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_we_o     (wb_we_o),
        .wb_sel_o    (wb_sel_o),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_o    (wb_dat_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        string       tag;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] model_data = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Selected slave answers as told; every other slave shouts ack+err with junk data.
    task automatic set_slaves(input int idx, input logic [31:0] rdata, input logic a, input logic e);
        for (int k = 0; k < NS; k++) begin
            if (k == idx) begin
                s_ack_i[k]           = a;
                s_err_i[k]           = e;
                s_data_i[k*32 +: 32] = rdata;
            end else begin
                s_ack_i[k]           = 1'b1;
                s_err_i[k]           = 1'b1;
                s_data_i[k*32 +: 32] = 32'hBAD0_0000 | 32'(k);
            end
        end
    endtask

    always @(negedge clk_i) begin
        if (mem_ready_o) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_ready", 32'd1, 32'd0);
            end else begin
                exp_t it;
                it = sb_q.pop_front();
                chk({it.tag, "_err"}, 32'(mem_err_o), 32'(it.err));
                chk({it.tag, "_data"}, mem_data_o, it.data);
            end
        end
    end

    // ack_at / err_at: 1-based BUS cycle in which the selected slave responds (0 = never).
    task automatic run_txn(input string tag, input logic [3:0] we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int ack_at, input int err_at);
        int          idx;
        int          term;
        int          bus_n;
        int          rdy_c;
        logic        e;
        logic [31:0] d;
        logic [2:0]  exp_cyc;
        idx  = int'(addr[17:16]);
        term = 0;
        e    = 1'b1;
        if (idx < NS) begin
            for (int k = 1; k <= TO; k++) begin
                if (err_at == k) begin term = k; e = 1'b1; break; end
                if (ack_at == k) begin term = k; e = 1'b0; break; end
            end
            if (term == 0) term = TO;
        end
        d          = e ? 32'h0 : ((we == 4'h0) ? rdata : model_data);
        model_data = d;
        exp_cyc    = (idx < NS) ? 3'(1 << idx) : 3'b000;
        sb_q.push_back('{tag, e, d});

        mem_req_i  = 1'b1;
        mem_we_i   = we;
        mem_addr_i = addr;
        mem_data_i = wdata;
        set_slaves(idx, rdata, 1'b0, 1'b0);
        bus_n = 0;
        rdy_c = 0;
        for (int c = 1; c <= 40 && rdy_c == 0; c++) begin
            @(negedge clk_i);
            mem_we_i   = ~we;
            mem_addr_i = addr ^ 32'h0003_5A5A;
            mem_data_i = ~wdata;
            if (wb_stb_o) begin
                bus_n++;
                chk({tag, "_cyc"}, 32'(s_cyc_o), 32'(exp_cyc));
                chk({tag, "_adr"}, 32'(wb_adr_o), 32'(addr[15:0]));
                chk({tag, "_we"}, 32'(wb_we_o), 32'(we != 4'h0));
                chk({tag, "_sel"}, 32'(wb_sel_o), 32'((we != 4'h0) ? we : 4'hF));
                chk({tag, "_dat"}, wb_dat_o, wdata);
            end
            if (mem_ready_o) rdy_c = c;
            set_slaves(idx, rdata, wb_stb_o && bus_n == ack_at, wb_stb_o && bus_n == err_at);
        end
        mem_req_i = 1'b0;
        set_slaves(idx, rdata, 1'b0, 1'b0);
        chk({tag, "_ready_cycle"}, 32'(rdy_c), 32'(term + 1));
        chk({tag, "_stb_cycles"}, 32'(bus_n), 32'((idx < NS) ? term : 0));
        @(negedge clk_i);
        chk({tag, "_ready_pulse"}, 32'(mem_ready_o), 32'd0);
        chk({tag, "_stb_after"}, 32'(wb_stb_o), 32'd0);
        chk({tag, "_data_held"}, mem_data_o, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] stb_pat;
        logic [4:0] rdy_pat;
        rst_n_i    = 1'b0;
        mem_req_i  = 1'b0;
        mem_we_i   = 4'h0;
        mem_addr_i = 32'h0;
        mem_data_i = 32'h0;
        s_ack_i    = '0;
        s_err_i    = '0;
        s_data_i   = '0;
        #12;
        chk("rst_cyc", 32'(s_cyc_o), 32'd0);
        chk("rst_stb", 32'(wb_stb_o), 32'd0);
        chk("rst_we", 32'(wb_we_o), 32'd0);
        chk("rst_sel", 32'(wb_sel_o), 32'd0);
        chk("rst_adr", 32'(wb_adr_o), 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        chk("rst_rdata", mem_data_o, 32'd0);
        chk("rst_ready", 32'(mem_ready_o), 32'd0);
        chk("rst_err", 32'(mem_err_o), 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        run_txn("wr_spi", 4'b0011, 32'h0001_0024, 32'hDEAD_BEEF, 32'h0, 2, 0);
        run_txn("rd_uart", 4'b0000, 32'h0000_0008, 32'h0, 32'h1234_5678, 1, 0);
        run_txn("rd_noslave", 4'b0000, 32'h0003_0010, 32'h0, 32'hCAFE_F00D, 1, 0);
        run_txn("rd_timeout", 4'b0000, 32'h0002_0040, 32'h0, 32'h7777_7777, 0, 0);
        run_txn("wr_ack_err", 4'b1111, 32'h0001_0100, 32'h0BAD_CAFE, 32'h0, 2, 2);
        run_txn("rd_ack_last", 4'b0000, 32'h0002_0080, 32'h0, 32'hA5A5_0F0F, TO, 0);
        run_txn("wr_err_only", 4'b0100, 32'h0000_0200, 32'h1111_2222, 32'h0, 0, 1);
        run_txn("rd_vga", 4'b0000, 32'h0002_0004, 32'h0, 32'h0102_0304, 3, 0);
        run_txn("wr_keep", 4'b1000, 32'h0000_0030, 32'h5566_7788, 32'hFFFF_FFFF, 1, 0);

        // Asynchronous reset in the middle of a BUS cycle.
        mem_req_i  = 1'b1;
        mem_we_i   = 4'h0;
        mem_addr_i = 32'h0002_0100;
        set_slaves(VGA_IDX, 32'h5555_AAAA, 1'b0, 1'b0);
        @(negedge clk_i);
        chk("arst_stb_before", 32'(wb_stb_o), 32'd1);
        chk("arst_cyc_before", 32'(s_cyc_o), 32'b100);
        mem_req_i = 1'b0;
        #2 rst_n_i = 1'b0;
        #1;
        chk("arst_stb_drop", 32'(wb_stb_o), 32'd0);
        chk("arst_cyc_drop", 32'(s_cyc_o), 32'd0);
        repeat (2) begin
            @(negedge clk_i);
            chk("arst_no_ready", 32'(mem_ready_o), 32'd0);
            chk("arst_adr", 32'(wb_adr_o), 32'd0);
        end
        chk("arst_rdata", mem_data_o, 32'd0);
        rst_n_i    = 1'b1;
        model_data = 32'h0;
        @(negedge clk_i);
        run_txn("after_rst", 4'b0000, 32'h0001_0010, 32'h0, 32'hFEED_0001, 1, 0);

        // mem_req_i held through DONE: the next transaction starts right after IDLE.
        sb_q.push_back('{"b2b_first", 1'b0, model_data});
        sb_q.push_back('{"b2b_second", 1'b0, model_data});
        mem_req_i  = 1'b1;
        mem_we_i   = 4'hF;
        mem_addr_i = 32'h0000_0040;
        mem_data_i = 32'h0A0B_0C0D;
        set_slaves(UART_IDX, 32'h0, 1'b0, 1'b0);
        stb_pat = '0;
        rdy_pat = '0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk_i);
            stb_pat[c-1] = wb_stb_o;
            rdy_pat[c-1] = mem_ready_o;
            if (c == 4) chk("b2b_we_second", 32'(wb_we_o), 32'd1);
            mem_we_i = (c == 1) ? 4'h0 : 4'hF;
            if (c == 5) mem_req_i = 1'b0;
            set_slaves(UART_IDX, 32'h0, wb_stb_o, 1'b0);
            if (c == 1) chk("b2b_we_first", 32'(wb_we_o), 32'd1);
        end
        set_slaves(UART_IDX, 32'h0, 1'b0, 1'b0);
        chk("b2b_stb_pattern", 32'(stb_pat), 32'b01001);
        chk("b2b_ready_pattern", 32'(rdy_pat), 32'b10010);
        @(negedge clk_i);
        chk("b2b_idle_stb", 32'(wb_stb_o), 32'd0);
        chk("b2b_idle_ready", 32'(mem_ready_o), 32'd0);
        repeat (2) @(negedge clk_i);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
